// File: rtl/ecc_channel_arbiter.sv
// Two-requester arbiter in front of a shared ECC data channel.
// A granted payload is held, driven to the channel, checked after CH_LAT
// cycles, re-issued on uncorrectable results up to MAX_RETRY times, and
// answered with a one-cycle response strobe to the requester that sent it.
module ecc_channel_arbiter #(
   parameter int CH_LAT    = 2,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] req_ready,
   output logic [1:0] rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic [7:0] ch_data_in,
   input  logic [7:0] ch_data_out,
   input  logic       ch_err_det,
   input  logic       ch_err_cor,
   output logic       busy,
   output logic [7:0] cor_cnt,
   output logic [7:0] unc_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_RESP
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(CH_LAT - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_hold;
   logic       r_grant;
   logic       r_last;
   logic [2:0] r_retry;
   logic [3:0] r_wait_cnt;
   logic [7:0] r_rsp_data;
   logic       r_rsp_err;
   logic [7:0] r_cor_cnt;
   logic [7:0] r_unc_cnt;

   logic       w_grant_idx;
   logic       w_handshake;
   logic       w_unc;
   logic       w_retry_ok;

   // Round-robin pick: on a tie the requester not served last wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_grant_idx = 1'b0;
      if (req_valid == 2'b11) begin
         w_grant_idx = ~r_last;
      end else if (req_valid[1]) begin
         w_grant_idx = 1'b1;
      end
   end

   // A transfer happens whenever IDLE sees any request; ready is the one-hot grant.
   assign w_handshake = (r_state == S_IDLE) && (req_valid != 2'b00);
   assign req_ready   = (w_handshake && rst) ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid   = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
   assign busy        = (r_state != S_IDLE);

   // Detected-but-not-corrected is the only error case; cor without det is clean.
   assign w_unc      = ch_err_det & ~ch_err_cor;
   assign w_retry_ok = (r_retry < RETRY_MAX);

   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign ch_data_in = r_hold;
   assign cor_cnt    = r_cor_cnt;
   assign unc_cnt    = r_unc_cnt;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_handshake) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (r_wait_cnt == 4'd0) w_next = S_CHECK;
         S_CHECK: w_next = (w_unc && w_retry_ok) ? S_ISSUE : S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: payload hold, latency counter, retry tracking, capture and statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold     <= 8'h00;
         r_grant    <= 1'b0;
         r_last     <= 1'b1;
         r_retry    <= 3'd0;
         r_wait_cnt <= 4'd0;
         r_rsp_data <= 8'h00;
         r_rsp_err  <= 1'b0;
         r_cor_cnt  <= 8'h00;
         r_unc_cnt  <= 8'h00;
      end else begin
         if (w_handshake) begin
            r_hold  <= w_grant_idx ? req_data1 : req_data0;
            r_grant <= w_grant_idx;
            r_retry <= 3'd0;
         end

         if (r_state == S_ISSUE) begin
            r_wait_cnt <= WAIT_LOAD;
         end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end

         if (r_state == S_CHECK) begin
            if (w_unc) begin
               if (r_unc_cnt != 8'hFF) r_unc_cnt <= r_unc_cnt + 8'd1;
               if (w_retry_ok) begin
                  r_retry <= r_retry + 3'd1;
               end else begin
                  r_rsp_data <= ch_data_out;
                  r_rsp_err  <= 1'b1;
               end
            end else begin
               r_rsp_data <= ch_data_out;
               r_rsp_err  <= 1'b0;
               if (ch_err_det && ch_err_cor && (r_cor_cnt != 8'hFF)) begin
                  r_cor_cnt <= r_cor_cnt + 8'd1;
               end
            end
         end

         if (r_state == S_RESP) begin
            r_last <= r_grant;
         end
      end
   end

endmodule

// File: tb/tb_ecc_channel_arbiter.sv
// Bench for ecc_channel_arbiter: a transaction-level model predicts grants,
// response timing, payloads and counters; a negedge process compares every
// cycle, and directed tests pin the model with hand-computed literals.
module tb_ecc_channel_arbiter;

   localparam int CH_LAT    = 2;
   localparam int MAX_RETRY = 3;
   localparam int WINDOW    = CH_LAT + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [7:0] req_data0 = 8'h00;
   logic [7:0] req_data1 = 8'h00;
   logic [1:0] req_ready;
   logic [1:0] rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [7:0] ch_data_in;
   logic [7:0] ch_data_out;
   logic       ch_err_det;
   logic       ch_err_cor;
   logic       busy;
   logic [7:0] cor_cnt;
   logic [7:0] unc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Channel knobs: first n_bad checks uncorrectable, then the base flags.
   int         n_bad    = 0;
   logic       base_det = 1'b0;
   logic       base_cor = 1'b0;
   logic [7:0] ch_mask  = 8'h00;
   int         ch_e     = 1000;

   ecc_channel_arbiter #(.CH_LAT(CH_LAT), .MAX_RETRY(MAX_RETRY)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .ch_data_in (ch_data_in),
      .ch_data_out(ch_data_out),
      .ch_err_det (ch_err_det),
      .ch_err_cor (ch_err_cor),
      .busy       (busy),
      .cor_cnt    (cor_cnt),
      .unc_cnt    (unc_cnt)
   );

   always #5 clk = ~clk;

   // Channel responder: the k-th check falls at ch_e == k*WINDOW after the handshake.
   assign ch_data_out = ch_data_in ^ ch_mask;
   assign ch_err_det  = (ch_e <= n_bad * WINDOW) ? 1'b1 : base_det;
   assign ch_err_cor  = (ch_e <= n_bad * WINDOW) ? 1'b0 : base_cor;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model + per-cycle compare ----------------
   int         cyc = 0;
   bit         m_pend = 1'b0;
   logic       m_last = 1'b1;
   int         m_idx = 0;
   int         m_when = 0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] m_rdata = 8'h00;
   logic       m_rerr = 1'b0;
   logic [7:0] m_pdata = 8'h00;
   logic       m_perr = 1'b0;
   int         m_cor = 0;
   int         m_unc = 0;
   int         m_dcor = 0;
   int         m_dunc = 0;
   int         m_neff = 0;
   logic [1:0] e_ready;
   logic [1:0] e_rsp;
   bit         is_resp;

   always @(negedge clk) begin
      if (!rst) begin
         m_pend  = 1'b0;
         m_last  = 1'b1;
         m_hold  = 8'h00;
         m_rdata = 8'h00;
         m_rerr  = 1'b0;
         m_cor   = 0;
         m_unc   = 0;
         ch_e    = 1000;
         check("reset_ctrl", {26'd0, req_ready, rsp_valid, rsp_err, busy}, 32'd0);
         check("reset_data", {rsp_data, ch_data_in, cor_cnt, unc_cnt}, 32'd0);
      end else begin
         cyc++;
         e_ready = 2'b00;
         if (!m_pend) begin
            if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
            else                    e_ready = req_valid;
         end
         is_resp = m_pend && (cyc == m_when);
         e_rsp   = is_resp ? ((m_idx == 1) ? 2'b10 : 2'b01) : 2'b00;
         if (is_resp) begin
            m_rdata = m_pdata;
            m_rerr  = m_perr;
            m_cor   = (m_cor + m_dcor > 255) ? 255 : m_cor + m_dcor;
            m_unc   = (m_unc + m_dunc > 255) ? 255 : m_unc + m_dunc;
         end
         check("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
         check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e_rsp});
         check("busy", {31'd0, busy}, {31'd0, m_pend});
         check("ch_data_in", {24'd0, ch_data_in}, {24'd0, m_hold});
         check("rsp_data", {24'd0, rsp_data}, {24'd0, m_rdata});
         check("rsp_err", {31'd0, rsp_err}, {31'd0, m_rerr});
         if (!m_pend || is_resp) begin
            check("cor_cnt", {24'd0, cor_cnt}, m_cor);
            check("unc_cnt", {24'd0, unc_cnt}, m_unc);
         end
         if (is_resp) begin
            m_pend = 1'b0;
            m_last = (m_idx == 1);
         end
         if (ch_e < 1000) ch_e++;
         if (e_ready != 2'b00) begin
            m_idx   = e_ready[1] ? 1 : 0;
            m_hold  = (m_idx == 1) ? req_data1 : req_data0;
            m_neff  = (n_bad < MAX_RETRY) ? n_bad : MAX_RETRY;
            m_perr  = (n_bad > MAX_RETRY);
            m_when  = cyc + CH_LAT + 3 + m_neff * WINDOW;
            m_pdata = m_hold ^ ch_mask;
            m_dunc  = m_perr ? MAX_RETRY + 1 : n_bad;
            m_dcor  = (!m_perr && base_det && base_cor) ? 1 : 0;
            m_pend  = 1'b1;
            ch_e    = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_req(input int idx, input logic [7:0] d, output logic [1:0] rdy,
                         output int lat, output logic [7:0] data, output logic err);
      bit hs  = 1'b0;
      bit got = 1'b0;
      rdy  = 2'b00;
      lat  = 0;
      data = 8'h00;
      err  = 1'b0;
      @(posedge clk); #1;
      if (idx == 0) req_data0 = d;
      else          req_data1 = d;
      req_valid = (idx == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            hs  = 1'b1;
            rdy = req_ready;
         end
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("handshake_seen", {31'd0, hs}, 32'd1);
      if (hs) begin
         lat = 1;
         while (!got && lat < 100) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
               got  = 1'b1;
               data = rsp_data;
               err  = rsp_err;
            end else begin
               lat++;
            end
         end
         check("response_seen", {31'd0, got}, 32'd1);
      end
   endtask

   task automatic set_channel(input int bad, input logic det, input logic cor, input logic [7:0] mask);
      n_bad    = bad;
      base_det = det;
      base_cor = cor;
      ch_mask  = mask;
   endtask

   logic [1:0] t_rdy;
   int         t_lat;
   logic [7:0] t_data;
   logic       t_err;
   logic [1:0] grants [8];
   logic [7:0] rdatas [8];
   int         ng;
   int         nr;
   int         seen;

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Clean pass from requester 0.
      set_channel(0, 1'b0, 1'b0, 8'h00);
      do_req(0, 8'hAA, t_rdy, t_lat, t_data, t_err);
      check("t1_ready", {30'd0, t_rdy}, 32'h1);
      check("t1_latency", t_lat, 5);
      check("t1_data", {24'd0, t_data}, 32'hAA);
      check("t1_err", {31'd0, t_err}, 32'd0);
      check("t1_counters", {16'd0, cor_cnt, unc_cnt}, 32'd0);

      // Corrected result: single pass, counted once.
      set_channel(0, 1'b1, 1'b1, 8'h01);
      do_req(0, 8'hF0, t_rdy, t_lat, t_data, t_err);
      check("t2_latency", t_lat, 5);
      check("t2_data", {24'd0, t_data}, 32'hF1);
      check("t2_err", {31'd0, t_err}, 32'd0);
      check("t2_cor_cnt", {24'd0, cor_cnt}, 32'd1);

      // cor flag without det: clean, not counted.
      set_channel(0, 1'b0, 1'b1, 8'h00);
      do_req(1, 8'h3C, t_rdy, t_lat, t_data, t_err);
      check("t3_ready", {30'd0, t_rdy}, 32'h2);
      check("t3_latency", t_lat, 5);
      check("t3_cor_cnt", {24'd0, cor_cnt}, 32'd1);

      // One uncorrectable check then clean: one re-issue.
      set_channel(1, 1'b0, 1'b0, 8'h00);
      do_req(0, 8'h5A, t_rdy, t_lat, t_data, t_err);
      check("t4_latency", t_lat, 9);
      check("t4_err", {31'd0, t_err}, 32'd0);
      check("t4_unc_cnt", {24'd0, unc_cnt}, 32'd1);

      // Always uncorrectable: retries exhausted.
      set_channel(99, 1'b0, 1'b0, 8'h00);
      do_req(1, 8'h77, t_rdy, t_lat, t_data, t_err);
      check("t5_latency", t_lat, 17);
      check("t5_err", {31'd0, t_err}, 32'd1);
      check("t5_data", {24'd0, t_data}, 32'h77);
      check("t5_unc_cnt", {24'd0, unc_cnt}, 32'd5);

      // Push unc_cnt past 255 to exercise saturation.
      for (int k = 0; k < 64; k++) begin
         do_req(k % 2, 8'(k * 3), t_rdy, t_lat, t_data, t_err);
      end
      check("t6_unc_saturated", {24'd0, unc_cnt}, 32'd255);
      check("t6_cor_kept", {24'd0, cor_cnt}, 32'd1);

      // Reset in WAIT: immediate zeroing, no response afterwards.
      set_channel(0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      req_data0 = 8'h44;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("t7_ctrl_immediate", {26'd0, req_ready, rsp_valid, rsp_err, busy}, 32'd0);
      check("t7_data_immediate", {rsp_data, ch_data_in, cor_cnt, unc_cnt}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) seen++;
      end
      check("t7_no_response", seen, 0);

      // Fresh request after reset completes normally.
      do_req(1, 8'h96, t_rdy, t_lat, t_data, t_err);
      check("t8_latency", t_lat, 5);
      check("t8_data", {24'd0, t_data}, 32'h96);

      // Both requesting every cycle: grants alternate starting with requester 0.
      @(posedge clk); #1;
      req_data0 = 8'h11;
      req_data1 = 8'h22;
      req_valid = 2'b11;
      ng = 0;
      nr = 0;
      for (int c = 0; c < 60 && nr < 4; c++) begin
         @(negedge clk);
         if (req_ready != 2'b00 && ng < 8) begin
            grants[ng] = req_ready;
            ng++;
         end
         if (rsp_valid != 2'b00 && nr < 8) begin
            rdatas[nr] = rsp_data;
            nr++;
         end
      end
      req_valid = 2'b00;
      check("t9_responses", nr, 4);
      for (int i = 0; i < 4; i++) begin
         check("t9_grant", {30'd0, grants[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
         check("t9_data", {24'd0, rdatas[i]}, (i % 2 == 0) ? 32'h11 : 32'h22);
      end

      repeat (3) @(negedge clk);
      check("nothing_outstanding", {31'd0, m_pend}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ecc_channel_arbiter.md
ECC_CHANNEL_ARBITER -- requirements
Module: ecc_channel_arbiter

Interface
REQ-001 The block SHALL have parameter CH_LAT, default 2, meaning cycles from ch_data_in applied to ch_data_out/flags valid (range 1..15).
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, meaning re-issues allowed after an uncorrectable result (range 0..7).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request (bit 0 = requester 0).
REQ-006 req_data0 / req_data1  input  8 each  payload of requester 0 / 1.
REQ-007 req_ready  output  2  one-hot acceptance; transfer when req_valid[i] & req_ready[i].
REQ-008 rsp_valid  output  2  one-cycle one-hot response strobe to the served requester.
REQ-009 rsp_data  output  8  channel output captured for the response.
REQ-010 rsp_err  output  1  response is uncorrectable after all retries; valid with rsp_valid.
REQ-011 ch_data_in  output  8  payload driven to the shared ECC data channel.
REQ-012 ch_data_out  input  8; ch_err_det  input  1; ch_err_cor  input  1  channel result and flags.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 cor_cnt / unc_cnt  output  8 each  saturating counts of corrected / uncorrectable channel results.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, CHECK, RESP; no other reachable states.
REQ-016 In IDLE, req_ready SHALL combinationally grant one requester with req_valid set; if both set, the one not served last; else the single valid one; none if req_valid = 0.
REQ-017 On handshake the selected payload SHALL be latched into a hold register, grant index stored, retry count cleared, next state ISSUE.
REQ-018 req_ready SHALL be 0 in all states except IDLE; req_valid changes outside IDLE SHALL have no effect.
REQ-019 ch_data_in SHALL equal the hold register from ISSUE through CHECK and keep that value in RESP/IDLE until the next handshake.
REQ-020 ISSUE SHALL last 1 cycle; WAIT SHALL last exactly CH_LAT cycles (down-counter); then CHECK.
REQ-021 CHECK SHALL sample ch_data_out, ch_err_det, ch_err_cor in that single cycle.
REQ-022 CHECK with err_det=0, or err_det=1 and err_cor=1: capture data, rsp_err=0, go RESP; cor_cnt +1 when err_cor=1.
REQ-023 CHECK with err_det=1 and err_cor=0: unc_cnt +1; if retry count < MAX_RETRY, increment it and go ISSUE; else capture data, rsp_err=1, go RESP.
REQ-024 ch_err_cor without ch_err_det SHALL be treated as no error and not counted.
REQ-025 RESP SHALL last 1 cycle with rsp_valid[grant]=1, rsp_data/rsp_err holding captured values; last-served updated; next state IDLE.
REQ-026 Latency SHALL be CH_LAT+3 cycles from handshake to rsp_valid (5 at default); each retry adds CH_LAT+2 cycles.
REQ-027 cor_cnt and unc_cnt SHALL saturate at 255 and never wrap.
REQ-028 rsp_data and rsp_err SHALL hold their last values outside RESP; rsp_valid SHALL be 0 outside RESP.
REQ-029 No response backpressure exists; a requester SHALL accept rsp_valid whenever it is asserted.

Reset
REQ-030 rst low SHALL immediately force state IDLE, and req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, ch_data_in=0, busy=0, cor_cnt=0, unc_cnt=0, retry count 0, last-served = requester 1 (requester 0 wins first tie).
REQ-031 Reset mid-transfer SHALL abort it with no response issued; after release the requester must re-request.

Verification
REQ-032 Requester 0 sends 0xAA, channel clean -> req_ready=01 at handshake, rsp_valid=01 five cycles later, rsp_data=0xAA, rsp_err=0, counters 0.
REQ-033 Both valid every cycle, data 0x11/0x22 -> grants alternate 0,1,0,1 starting with requester 0; responses match respective data.
REQ-034 Channel reports det=1,cor=1 on 0xF0 -> single pass, rsp_err=0, cor_cnt=1, latency 5.
REQ-035 Channel reports det=1,cor=0 on first CHECK then clean -> one re-issue, unc_cnt=1, rsp_err=0, latency 9.
REQ-036 Channel always det=1,cor=0 -> 4 CHECKs, rsp_err=1, unc_cnt=4, latency 5+3*4=17.
REQ-037 Assert rst low during WAIT -> all outputs zero immediately, no rsp_valid; new request afterwards completes normally with latency 5.
